// File: rtl/step_counter_pkg.sv
// Shared types for the step_counter block.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

endpackage

// File: rtl/step_counter_if.sv
// Control/status bundle for step_counter; the prescale field exists only with STEP_COUNTER_PRESCALE_EN.
interface step_counter_if #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned PRESCALE_W = 8
);
    import counter_pkg::*;

    logic             en;
    logic             up;
    cnt_mode_t        mode;
    logic [WIDTH-1:0] limit;
    logic             load;
    logic [WIDTH-1:0] load_value;
`ifdef STEP_COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic [WIDTH-1:0] value;
    logic             tc;

`ifdef STEP_COUNTER_PRESCALE_EN
    modport master (output en, up, mode, limit, load, load_value, prescale, input value, tc);
    modport slave  (input en, up, mode, limit, load, load_value, prescale, output value, tc);
`else
    modport master (output en, up, mode, limit, load, load_value, input value, tc);
    modport slave  (input en, up, mode, limit, load, load_value, output value, tc);
`endif

endinterface

// File: rtl/step_counter_tick_prescaler.sv
// Clock-enable divider: one tick every prescale+1 enabled cycles.
// Compiled only when STEP_COUNTER_PRESCALE_EN is defined.
`ifdef STEP_COUNTER_PRESCALE_EN
module tick_prescaler #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pc_q;
    logic [PRESCALE_W-1:0] pc_d;

    // >= rather than == so lowering prescale below pc never stalls the count
    assign tick = en && (pc_q >= prescale);

    always_comb begin
        pc_d = pc_q;
        if (clr || tick) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = pc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
`endif

// File: rtl/step_counter.sv
// Programmable up/down counter with runtime limit, load, wrap/saturate and terminal-count pulse.
// Optional prescaler enabled by STEP_COUNTER_PRESCALE_EN.
module step_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned STEP       = 1,
    parameter int unsigned PRESCALE_W = 8
) (
    input logic           clk,
    input logic           reset,
    step_counter_if.slave bus
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam logic [W1-1:0] STEP_X = W1'(STEP);

    if (STEP == 0) begin : g_bad_step
        $error("step_counter: STEP must be at least 1");
    end
    if (PRESCALE_W == 0) begin : g_bad_prescale_w
        $error("step_counter: PRESCALE_W must be at least 1");
    end

    logic tick;

`ifdef STEP_COUNTER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .clr      (bus.load),
        .en       (bus.en),
        .prescale (bus.prescale),
        .tick     (tick)
    );
`else
    assign tick = bus.en;
`endif

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             tc_q;
    logic             tc_d;

    logic [W1-1:0] cur;
    logic [W1-1:0] lim;
    logic [W1-1:0] lim1;
    logic [W1-1:0] sum_up;
    logic [W1-1:0] wrap_up;
    logic [W1-1:0] diff_dn;
    logic [W1-1:0] wrap_dn;

    // All bound arithmetic at WIDTH+1 bits so nothing truncates before comparison
    always_comb begin
        value_d = value_q;
        tc_d    = 1'b0;
        cur     = {1'b0, value_q};
        lim     = {1'b0, bus.limit};
        lim1    = lim + W1'(1);
        sum_up  = cur + STEP_X;
        wrap_up = sum_up - lim1;
        diff_dn = cur - STEP_X;
        wrap_dn = cur + lim1 - STEP_X;

        if (bus.load) begin
            value_d = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;
        end else if (tick) begin
            if (bus.up) begin
                if (sum_up <= lim) begin
                    value_d = WIDTH'(sum_up);
                end else begin
                    tc_d = 1'b1;
                    if (bus.mode == CNT_SAT) begin
                        value_d = bus.limit;
                    end else if (wrap_up > lim) begin
                        value_d = '0;
                    end else begin
                        value_d = WIDTH'(wrap_up);
                    end
                end
            end else begin
                if (cur >= STEP_X) begin
                    // limit may have been lowered beneath the count; clamp the stepped result
                    value_d = (diff_dn > lim) ? bus.limit : WIDTH'(diff_dn);
                end else begin
                    tc_d = 1'b1;
                    if (bus.mode == CNT_SAT) begin
                        value_d = '0;
                    end else if (wrap_dn > lim) begin
                        value_d = bus.limit;
                    end else begin
                        value_d = WIDTH'(wrap_dn);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            value_q <= value_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.value = value_q;
    assign bus.tc    = tc_q;

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised programmable counter: the successor to the team's basic free-running counter. It adds a runtime modulus limit, up/down direction, parallel load, wrap or saturate mode, a registered terminal-count pulse and an optional clock-enable prescaler. It is the standard timebase and event counter for display multiplexing, debouncing and tone-generation blocks in the FPGA design.

## Interface
Parameters:
- `WIDTH`, 24: counter width in bits.
- `STEP`, 1: increment/decrement per tick; legal range 1 to 2^WIDTH-1.
- `PRESCALE_W`, 8: width of the prescaler divide input; used only when the prescaler is compiled in.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `en`  in  1: count enable; gates the prescaler and steps.
- `up`  in  1: 1 = count up, 0 = count down.
- `mode`  in  1 (`cnt_mode_t`): `CNT_WRAP` = 0 (modulo), `CNT_SAT` = 1 (clamp at bound).
- `limit`  in  WIDTH: top value; the count range is 0..limit; all-ones reproduces a plain WIDTH-bit counter.
- `load`  in  1: parallel load strobe.
- `load_value`  in  WIDTH: value to load.
- `prescale`  in  PRESCALE_W: tick every prescale+1 enabled cycles; present only with the prescaler macro.
- `value`  out  WIDTH: registered count.
- `tc`  out  1: registered one-cycle terminal-count pulse.

## Operation
- Priority each cycle: reset > load > tick > hold.
- Reset: `value` = 0, `tc` = 0, prescaler count = 0.
- Load: `value` <= min(`load_value`, `limit`); `tc` <= 0; prescaler count <= 0. A tick in the same cycle is discarded.
- Tick: without the prescaler, tick = `en`. With it, see Configuration.
- Arithmetic is done at WIDTH+1 bits. No intermediate result may truncate.
- Up tick, with s = value + STEP:
  - If s <= limit: `value` <= s.
  - Otherwise it is an overflow. WRAP: `value` <= s - (limit+1); if that result still exceeds limit, `value` <= 0. SAT: `value` <= limit.
- Down tick:
  - If value >= STEP: `value` <= value - STEP.
  - Otherwise it is an underflow. WRAP: `value` <= value + (limit+1) - STEP; if that result exceeds limit, `value` <= limit. SAT: `value` <= 0.
- `tc`: <= 1 on any tick that overflows or underflows, in either mode. It is 0 on every other cycle.
  - In SAT mode, each further tick that is held at the bound pulses `tc` again.
- `limit` lowered below the current `value` at runtime: the next up tick counts as an overflow. A down tick steps normally from the current value and is then bounds-checked.
- `up`, `mode` and `limit` are sampled only on tick cycles. Changing them between ticks has no effect.

## Timing
- `value` and `tc` update on the edge that ends the tick cycle. Latency from tick to output is 1 cycle.
- `tc` and the new `value` appear together and hold for exactly one cycle, unless the next cycle is also an overflow/underflow tick.
- Reset and load take effect on the next edge. No extra cycles are required after deassertion.

## Configuration
- Macro: `STEP_COUNTER_PRESCALE_EN`.
- Defined:
  - A PRESCALE_W-bit prescaler count pc advances only while `en` = 1.
  - tick = `en` && (pc >= `prescale`). On a tick, pc <= 0; otherwise, while `en` = 1, pc <= pc+1.
  - `en` = 0 freezes pc.
  - Using >= prevents a stall when `prescale` is lowered below pc.
- Undefined: the `prescale` port and the pc register are absent, and tick = `en`.

## Structure
- Package `counter_pkg`: `cnt_mode_t` enum (`CNT_WRAP`, `CNT_SAT`).
- Sub-module `tick_prescaler`, instantiated only under the macro.
  - Inputs: `clk`, `reset`, `clr` (load), `en`, `prescale`.
  - Output: `tick`.
- Step, bound and `tc` logic stay in `step_counter`.

## Test plan
- WIDTH=8, STEP=1, limit=255, WRAP, up, `en` held high from reset: after 256 ticks `value` = 0, with exactly one `tc` pulse coincident with the 255->0 transition.
- limit=9, STEP=3, WRAP, up: `value` sequence 0,3,6,9,2,5,8,1; `tc` on 9->2 and on 8->1 only.
- limit=9, STEP=3, SAT, down, after load of 4: `value` sequence 4,1,0,0; `tc` on the 1->0 step and on the 0->0 step.
- `load`=1 with `load_value`=20, limit=9, and `en`=1 in the same cycle: `value` = 9 next cycle, `tc` = 0, no step applied.
- With the macro defined, prescale=2 and `en` high: `value` increments on every 3rd cycle. Dropping `en` for 5 cycles freezes both `value` and pc. With prescale=0, `value` increments every cycle.
- `reset` asserted mid-count (`value`=7, `tc` pulsing, pc=1): next cycle `value` = 0, `tc` = 0, pc = 0, and the first tick after release arrives prescale+1 enabled cycles later.
